// File: rtl/apb_mig_sync_bridge.sv
// apb_mig_sync_bridge: single-clock APB slave feeding a MIG-style user port.
// Writes are posted into a CMD_DEPTH-entry command queue (zero wait states
// while the queue has room). Reads are queued behind every earlier write and
// the APB transfer is held until the MIG returns data. Addresses with any bit
// set above MIG_ADDR_W are answered at once with pslverr_o and push nothing.
// Optional macro APB_MIG_SYNC_TIMEOUT_EN adds a read watchdog: a read that
// waits TIMEOUT_CYCLES cycles ends with pslverr_o=1 and prdata_o=0, and its
// late return data is discarded.
// Ports:
//   clk_i, rst_i                shared clock, synchronous active-high reset
//   psel_i, penable_i, pwrite_i APB control
//   paddr_i, pwdata_i, pstrb_i  APB address, write data, byte strobes
//   prdata_o, pready_o          APB read data, transfer complete
//   pslverr_o                   APB transfer error
//   mig_en_o, mig_w_en_o        command issue / write command+data strobes
//   mig_addr_o, mig_data_o      command address and write data (queue head)
//   mig_strb_o                  write byte strobes (queue head)
//   mig_ready_i, mig_w_ready_i  MIG accepts command / write data
//   mig_data_i, mig_valid_i     MIG read return data and valid
module apb_mig_sync_bridge #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int MIG_ADDR_W     = 27,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_W-1:0]     paddr_i,
    input  logic [DATA_W-1:0]     pwdata_i,
    input  logic [DATA_W/8-1:0]   pstrb_i,
    output logic [DATA_W-1:0]     prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic                  mig_en_o,
    output logic                  mig_w_en_o,
    output logic [MIG_ADDR_W-1:0] mig_addr_o,
    output logic [DATA_W-1:0]     mig_data_o,
    output logic [DATA_W/8-1:0]   mig_strb_o,
    input  logic                  mig_ready_i,
    input  logic                  mig_w_ready_i,
    input  logic [DATA_W-1:0]     mig_data_i,
    input  logic                  mig_valid_i
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(CMD_DEPTH);
    localparam int DROP_W = $clog2(CMD_DEPTH) + 1;
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef struct packed {
        logic                  write;
        logic [MIG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic [STRB_W-1:0]     strb;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_t;

    state_t state, state_n;

    cmd_t             mem [CMD_DEPTH];
    cmd_t             head;
    cmd_t             push_cmd;
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    logic             access;
    logic             range_err;
    logic             capture;
    logic             timeout;
    logic [DROP_W-1:0] drop_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic             err_q;

    // ---------------------------------------------------------------
    // Command queue. Extra pointer MSB separates full from empty.
    // ---------------------------------------------------------------
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    // A read at the head needs no write-data channel.
    assign pop = !empty && mig_ready_i && (mig_w_ready_i || !head.write);

    always_comb begin
        push_cmd       = '0;
        push_cmd.write = pwrite_i;
        push_cmd.addr  = paddr_i[MIG_ADDR_W-1:0];
        if (pwrite_i) begin
            push_cmd.data = pwdata_i;
            push_cmd.strb = pstrb_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < CMD_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[PTR_W-1:0]] <= push_cmd;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign mig_en_o   = pop;
    assign mig_w_en_o = pop && head.write;
    assign mig_addr_o = head.addr;
    assign mig_data_o = head.data;
    assign mig_strb_o = head.strb;

    // ---------------------------------------------------------------
    // APB side
    // ---------------------------------------------------------------
    assign access    = psel_i && penable_i;
    assign range_err = (paddr_i >> MIG_ADDR_W) != '0;

    // Return data owed to a timed-out read is swallowed, not captured.
    assign capture = (state == RD_WAIT) && mig_valid_i &&
                     (drop_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        push      = 1'b0;
        pready_o  = 1'b0;
        pslverr_o = 1'b0;
        prdata_o  = '0;
        unique case (state)
            IDLE: begin
                if (access) begin
                    if (range_err) begin
                        pready_o  = 1'b1;
                        pslverr_o = 1'b1;
                    end else if (!full) begin
                        push = 1'b1;
                        if (pwrite_i) begin
                            pready_o = 1'b1;
                        end else begin
                            state_n = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (capture || timeout) begin
                    state_n = RD_DONE;
                end
            end
            RD_DONE: begin
                pready_o  = 1'b1;
                prdata_o  = rdata_q;
                pslverr_o = err_q;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (capture) begin
            rdata_q <= mig_data_i;
            err_q   <= 1'b0;
        end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Read watchdog
    // ---------------------------------------------------------------
`ifdef APB_MIG_SYNC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_ONE   = 1;
    localparam logic [DROP_W-1:0] DROP_ONE = 1;
    localparam logic [DROP_W-1:0] DROP_MAX = DROP_W'(CMD_DEPTH);

    logic [WD_W-1:0] wd_cnt;
    logic            drop_inc;
    logic            drop_dec;

    // Same-cycle return data beats the watchdog.
    assign timeout  = (state == RD_WAIT) && !mig_valid_i &&
                      (wd_cnt >= WD_LIMIT);
    assign drop_inc = timeout && (drop_cnt != DROP_MAX);
    assign drop_dec = mig_valid_i && (drop_cnt != '0);

    // Held at zero outside RD_WAIT, so every read starts from 0.
    always_ff @(posedge clk_i) begin
        if (rst_i || (state != RD_WAIT)) begin
            wd_cnt <= '0;
        end else if (wd_cnt < WD_LIMIT) begin
            wd_cnt <= wd_cnt + WD_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt <= '0;
        end else if (drop_inc && !drop_dec) begin
            drop_cnt <= drop_cnt + DROP_ONE;
        end else if (drop_dec && !drop_inc) begin
            drop_cnt <= drop_cnt - DROP_ONE;
        end
    end
`else
    assign timeout  = 1'b0;
    assign drop_cnt = '0;
`endif

endmodule
